tx_fifo_wr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares the single write port of a tx_intf
//  xpm_fifo_sync instance between NUM_REQ producers, e.g. per-queue DMA streams.

---
 rtl/tx_fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_tx_fifo_wr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_wr_arbiter.sv
// Purpose : packet-granular round-robin arbiter sharing one xpm_fifo_sync write port
//           between NUM_REQ producers; a grant is held from first beat to last beat.
// Latency : req_valid at cycle N -> first FIFO write at N+1 (one IDLE arbitration cycle
//           per packet); within a packet, beats pass through combinationally.
// Backpr. : fifo_full or fifo_wr_rst_busy drop req_ready of the granted requester, so the
//           producer holds its beat; requesters that are not granted always see ready=0.
// Ports   :
//   clk, rstn                     clock (rising edge) and asynchronous active-low reset
//   req_valid/req_last/req_data   per-requester beat stream, data packed i*DATA_WIDTH
//   req_ready                     per-requester accept, one-hot or zero
//   fifo_din/fifo_wr_en           FIFO write port
//   fifo_full/fifo_wr_rst_busy    FIFO status; either one stalls the write port
//   grant_id                      current (or most recent) granted requester
//   busy                          high while a packet is in flight
//   pkt_trunc                     one-cycle pulse, the cycle after a packet is force-closed
//                                 at MAX_BEATS beats

module tx_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 1024
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_rst_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          pkt_trunc
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(MAX_BEATS) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  grant_q;
  logic [CNTW-1:0] beat_cnt_q;
  logic [CNTW-1:0] beat_cnt_d;
  logic            trunc_q;

  // Round-robin search result
  logic [IDW-1:0]  winner;
  logic            win_found;
  logic [IDW-1:0]  idx;

  // Granted-requester datapath
  logic                  xfer;
  logic                  can_wr;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  accept;
  logic                  at_max;

  // Search starts one past the last served requester so every producer gets a turn
  // before any producer is served twice.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        winner    = idx;
      end
    end
  end

  assign xfer    = (state_q == XFER);
  assign can_wr  = !fifo_full && !fifo_wr_rst_busy;
  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];
  assign g_data  = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign accept  = xfer && g_valid && can_wr;

  // Ready is offered to the granted requester whenever the FIFO can take a beat,
  // independent of its valid, so the handshake has no valid->ready dependency.
  always_comb begin
    req_ready = '0;
    if (xfer && can_wr) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign fifo_wr_en = accept;
  assign fifo_din   = xfer ? g_data : '0;

  assign beat_cnt_d = beat_cnt_q + CNTW'(1);
  // Current beat is number MAX_BEATS of the packet: no further beats may join it.
  assign at_max     = (beat_cnt_q == CNTW'(MAX_BEATS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
      grant_q    <= '0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A FIFO still coming out of reset cannot take a write, so do not open a packet.
          if (win_found && !fifo_wr_rst_busy) begin
            state_q    <= XFER;
            grant_q    <= winner;
            beat_cnt_q <= '0;
          end
        end
        XFER: begin
          // Gaps in the granted requester's valid keep the grant; only an accepted
          // last beat or the beat limit closes the packet.
          if (accept) begin
            beat_cnt_q <= beat_cnt_d;
            if (g_last) begin
              state_q  <= IDLE;
              rr_ptr_q <= grant_q;
            end else if (at_max) begin
              // Runaway packet: close it; the requester's remaining beats compete
              // again as a fresh packet.
              trunc_q  <= 1'b1;
              state_q  <= IDLE;
              rr_ptr_q <= grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == XFER);
  assign pkt_trunc = trunc_q;

endmodule

// File: tb/tb_tx_fifo_wr_arbiter.sv
module tb_tx_fifo_wr_arbiter;

  logic             clk;
  logic             rstn;
  logic [3:0]       req_valid;
  logic [3:0]       req_last;
  logic [3:0][63:0] dat;
  logic [255:0]     req_data;
  logic             fifo_full;
  logic             fifo_wr_rst_busy;

  // Instance A: large beat limit; instance B: MAX_BEATS=4 for forced termination.
  logic [3:0]  rdy_a, rdy_b;
  logic [63:0] din_a, din_b;
  logic        wen_a, wen_b;
  logic [1:0]  gid_a, gid_b;
  logic        busy_a, busy_b;
  logic        trunc_a, trunc_b;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt;
  int b;
  logic [3:0]  full_sched [7];

  assign req_data = dat;

  tx_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .MAX_BEATS(16)) dut_a (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(rdy_a), .fifo_din(din_a), .fifo_wr_en(wen_a),
    .fifo_full(fifo_full), .fifo_wr_rst_busy(fifo_wr_rst_busy),
    .grant_id(gid_a), .busy(busy_a), .pkt_trunc(trunc_a)
  );

  tx_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .MAX_BEATS(4)) dut_b (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(rdy_b), .fifo_din(din_b), .fifo_wr_en(wen_b),
    .fifo_full(fifo_full), .fifo_wr_rst_busy(fifo_wr_rst_busy),
    .grant_id(gid_b), .busy(busy_b), .pkt_trunc(trunc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs are changed 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid        = '0;
    req_last         = '0;
    dat              = '0;
    fifo_full        = 1'b0;
    fifo_wr_rst_busy = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    #2;
    chk("rst_busy",  64'(busy_a),  64'd0);
    chk("rst_gid",   64'(gid_a),   64'd0);
    chk("rst_wen",   64'(wen_a),   64'd0);
    chk("rst_rdy",   64'(rdy_a),   64'd0);
    chk("rst_din",   din_a,        64'd0);
    chk("rst_trunc", 64'(trunc_a), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // 1: four single-beat packets at once; req0 re-requests with a second packet.
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 4; i++) dat[i] = 64'h1000 + 64'(i);
    wr_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t1_idle_busy", 64'(busy_a), 64'd0);
      chk("t1_idle_wen",  64'(wen_a),  64'd0);
      chk("t1_idle_rdy",  64'(rdy_a),  64'd0);
      tick();
      #1;
      chk("t1_busy", 64'(busy_a), 64'd1);
      chk("t1_gid",  64'(gid_a),  64'(k % 4));
      chk("t1_rdy",  64'(rdy_a),  64'(4'b0001 << (k % 4)));
      chk("t1_wen",  64'(wen_a),  64'd1);
      chk("t1_din",  din_a, (k == 4) ? 64'h2000 : 64'h1000 + 64'(k % 4));
      if (wen_a) wr_cnt++;
      if (k == 3) chk("t1_writes_in_8", 64'(wr_cnt), 64'd4);
      tick();
      if (k == 0) dat[0] = 64'h2000;
      else        req_valid[k % 4] = 1'b0;
    end

    // 2: 5-beat packet on req1 while req2 waits.
    do_reset();
    req_valid = 4'b0110;
    req_last  = 4'b0100;
    dat[2]    = 64'h4000;
    dat[1]    = 64'h3000;
    #1;
    chk("t2_idle_wen", 64'(wen_a), 64'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      dat[1]      = 64'h3000 + 64'(i);
      req_last[1] = (i == 4);
      #1;
      chk("t2_gid", 64'(gid_a), 64'd1);
      chk("t2_wen", 64'(wen_a), 64'd1);
      chk("t2_din", din_a, 64'h3000 + 64'(i));
      chk("t2_rdy", 64'(rdy_a), 64'b0010);
      tick();
    end
    req_valid[1] = 1'b0;
    #1;
    chk("t2_gap_busy", 64'(busy_a), 64'd0);
    tick();
    #1;
    chk("t2_gid2", 64'(gid_a), 64'd2);
    chk("t2_din2", din_a, 64'h4000);
    chk("t2_wen2", 64'(wen_a), 64'd1);
    tick();
    req_valid = '0;

    // 3: FIFO full for three cycles in the middle of a 4-beat packet on req3.
    do_reset();
    full_sched = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
    req_valid  = 4'b1000;
    dat[3]     = 64'h5000;
    #1;
    tick();
    b = 0;
    for (int c = 0; c < 7; c++) begin
      dat[3]      = 64'h5000 + 64'(b);
      req_last[3] = (b == 3);
      fifo_full   = full_sched[c][0];
      #1;
      chk("t3_gid", 64'(gid_a), 64'd3);
      if (fifo_full) begin
        chk("t3_full_wen",  64'(wen_a),  64'd0);
        chk("t3_full_rdy",  64'(rdy_a),  64'd0);
        chk("t3_full_busy", 64'(busy_a), 64'd1);
      end else begin
        chk("t3_wen", 64'(wen_a), 64'd1);
        chk("t3_din", din_a, 64'h5000 + 64'(b));
        b++;
      end
      tick();
    end
    fifo_full = 1'b0;
    req_valid = '0;
    #1;
    chk("t3_done_busy", 64'(busy_a), 64'd0);

    // 4: MAX_BEATS=4 instance, req0 streams 6 beats, last only on the 6th.
    do_reset();
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    dat[0]    = 64'h6000;
    #1;
    chk("t4_idle_busy", 64'(busy_b), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      dat[0] = 64'h6000 + 64'(i);
      #1;
      chk("t4_wen",   64'(wen_b),   64'd1);
      chk("t4_din",   din_b,        64'h6000 + 64'(i));
      chk("t4_trunc", 64'(trunc_b), 64'd0);
      tick();
    end
    dat[0] = 64'h6004;
    #1;
    chk("t4_trunc_pulse", 64'(trunc_b), 64'd1);
    chk("t4_trunc_busy",  64'(busy_b),  64'd0);
    chk("t4_trunc_wen",   64'(wen_b),   64'd0);
    tick();
    for (int i = 4; i < 6; i++) begin
      dat[0]      = 64'h6000 + 64'(i);
      req_last[0] = (i == 5);
      #1;
      chk("t4_re_gid",   64'(gid_b),   64'd0);
      chk("t4_re_wen",   64'(wen_b),   64'd1);
      chk("t4_re_din",   din_b,        64'h6000 + 64'(i));
      chk("t4_re_trunc", 64'(trunc_b), 64'd0);
      tick();
    end
    req_valid = '0;
    #1;
    chk("t4_end_busy",  64'(busy_b),  64'd0);
    chk("t4_end_trunc", 64'(trunc_b), 64'd0);

    // 5: wr_rst_busy holds off arbitration, then stalls an open packet like full.
    do_reset();
    fifo_wr_rst_busy = 1'b1;
    req_valid        = 4'b0001;
    dat[0]           = 64'h7000;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_hold_busy", 64'(busy_a), 64'd0);
      chk("t5_hold_wen",  64'(wen_a),  64'd0);
      tick();
    end
    fifo_wr_rst_busy = 1'b0;
    #1;
    chk("t5_rel_busy", 64'(busy_a), 64'd0);
    tick();
    #1;
    chk("t5_xfer_busy", 64'(busy_a), 64'd1);
    chk("t5_xfer_wen",  64'(wen_a),  64'd1);
    chk("t5_xfer_din",  din_a,       64'h7000);
    tick();
    fifo_wr_rst_busy = 1'b1;
    dat[0]           = 64'h7001;
    req_last[0]      = 1'b1;
    #1;
    chk("t5_rb_wen",  64'(wen_a),  64'd0);
    chk("t5_rb_rdy",  64'(rdy_a),  64'd0);
    chk("t5_rb_busy", 64'(busy_a), 64'd1);
    tick();
    fifo_wr_rst_busy = 1'b0;
    #1;
    chk("t5_last_wen", 64'(wen_a), 64'd1);
    chk("t5_last_din", din_a,      64'h7001);
    tick();
    req_valid = '0;
    #1;
    chk("t5_end_busy", 64'(busy_a), 64'd0);

    // 6: asynchronous reset in the middle of a packet on req2.
    do_reset();
    req_valid = 4'b0100;
    dat[2]    = 64'h8000;
    #1;
    tick();
    #1;
    chk("t6_pre_gid", 64'(gid_a), 64'd2);
    chk("t6_pre_wen", 64'(wen_a), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_ar_busy", 64'(busy_a), 64'd0);
    chk("t6_ar_gid",  64'(gid_a),  64'd0);
    chk("t6_ar_wen",  64'(wen_a),  64'd0);
    chk("t6_ar_rdy",  64'(rdy_a),  64'd0);
    chk("t6_ar_din",  din_a,       64'd0);
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 4; i++) dat[i] = 64'h9000 + 64'(i);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    #1;
    chk("t6_post_gid",  64'(gid_a),  64'd0);
    chk("t6_post_busy", 64'(busy_a), 64'd1);
    chk("t6_post_din",  din_a,       64'h9000);
    tick();
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
